// File: rtl/rr_bus_arbiter_if.sv
// Result-bus bundle between the four requesters, the arbiter and the consumer.
// The master view is the arbiter; the slave view is the requester/consumer side.
interface rr_bus_arbiter_if #(
    parameter int WIDTH = 16
);
    logic [3:0]       req;
    logic [3:0]       last;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] data3;
    logic             outReady;
    logic [3:0]       grant;
    logic [1:0]       sel;
    logic             outValid;
    logic [WIDTH-1:0] outData;
    logic [3:0]       beatAck;

    modport master (
        input  req, last, data0, data1, data2, data3, outReady,
        output grant, sel, outValid, outData, beatAck
    );

    modport slave (
        output req, last, data0, data1, data2, data3, outReady,
        input  grant, sel, outValid, outData, beatAck
    );
endinterface

// File: rtl/rr_bus_arbiter.sv
// Round-robin burst arbiter for the shared 16-bit result bus.
// Grants are registered; valid/data/ack are decoded from the current grant.
module rr_bus_arbiter #(
    parameter int WIDTH     = 16,
    parameter int MAX_BEATS = 8
) (
    input  logic              clk,
    input  logic              rst,
    rr_bus_arbiter_if.master  bus
);
    localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_sel;
    logic [3:0]       r_grant;
    logic [CW-1:0]    r_beat_cnt;

    logic             w_busy;
    logic             w_valid;
    logic             w_xfer;
    logic             w_release;
    logic             w_found;
    logic [1:0]       w_pick;
    logic [1:0]       w_idx;
    logic [WIDTH-1:0] w_data_sel;

    // Scan from the highest offset down so the nearest requester wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_idx   = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (bus.req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_data_sel = '0;
        unique case (r_sel)
            2'd0: w_data_sel = bus.data0;
            2'd1: w_data_sel = bus.data1;
            2'd2: w_data_sel = bus.data2;
            2'd3: w_data_sel = bus.data3;
        endcase
    end

    assign w_busy    = (r_state == BUSY);
    // Reset suppresses any beat that would otherwise land in the reset cycle.
    assign w_valid   = w_busy & bus.req[r_sel] & ~rst;
    assign w_xfer    = w_valid & bus.outReady;
    assign w_release = (w_xfer & (bus.last[r_sel] | (r_beat_cnt == LAST_CNT)))
                     | (w_busy & ~bus.req[r_sel]);

    assign bus.grant    = r_grant;
    assign bus.sel      = r_sel;
    assign bus.outValid = w_valid;
    assign bus.outData  = w_busy ? w_data_sel : '0;
    assign bus.beatAck  = w_xfer ? (4'b0001 << r_sel) : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= 2'd0;
            r_sel      <= 2'd0;
            r_grant    <= 4'b0000;
            r_beat_cnt <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_sel      <= w_pick;
                        r_grant    <= 4'b0001 << w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_xfer)
                        r_beat_cnt <= r_beat_cnt + CW'(1);
                    if (w_release) begin
                        r_state <= IDLE;
                        r_grant <= 4'b0000;
                        r_ptr   <= r_sel + 2'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Vector-table bench for rr_bus_arbiter: each row gives one cycle of inputs
// and the outputs expected in that same cycle; a queue pairs them up.
module tb_rr_bus_arbiter;
    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  last;
        logic        rdy;
        logic [15:0] d2;
        logic [3:0]  g;
        logic [1:0]  s;
        logic        v;
        logic [3:0]  a;
    } vec_t;

    localparam logic [15:0] D0 = 16'hA0A0;
    localparam logic [15:0] D1 = 16'hB1B1;
    localparam logic [15:0] D3 = 16'hD3D3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    rr_bus_arbiter_if #(.WIDTH(16)) bus ();

    rr_bus_arbiter #(.WIDTH(16), .MAX_BEATS(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                       input logic rd, input logic [15:0] d2,
                       input logic [3:0] g, input logic [1:0] s,
                       input logic v, input logic [3:0] a);
        vec_t t;
        t.rst = r; t.req = rq; t.last = ls; t.rdy = rd; t.d2 = d2;
        t.g = g; t.s = s; t.v = v; t.a = a;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req_v, $time);
        end
    endtask

    function automatic logic [15:0] dsel(input logic [1:0] s, input logic [15:0] d2);
        case (s)
            2'd0: return D0;
            2'd1: return D1;
            2'd2: return d2;
            default: return D3;
        endcase
    endfunction

    initial begin
        vec_t  e;
        vec_t  prev;
        logic  have_prev;
        logic [3:0] prev_ack;

        rst = 1'b1;
        bus.req = 4'b0; bus.last = 4'b0; bus.outReady = 1'b0;
        bus.data0 = D0; bus.data1 = D1; bus.data2 = 16'h0; bus.data3 = D3;

        // reset with all requests pending
        add(1, 4'hF, 4'hF, 1, 16'h0,    4'h0, 2'd0, 0, 4'h0);
        add(1, 4'hF, 4'hF, 1, 16'h0,    4'h0, 2'd0, 0, 4'h0);
        // fairness: single-beat bursts 0,1,2,3,0
        add(0, 4'hF, 4'hF, 1, 16'h0,    4'h0, 2'd0, 0, 4'h0);
        add(0, 4'hF, 4'hF, 1, 16'h0,    4'h1, 2'd0, 1, 4'h1);
        add(0, 4'hF, 4'hF, 1, 16'h0,    4'h0, 2'd0, 0, 4'h0);
        add(0, 4'hF, 4'hF, 1, 16'h0,    4'h2, 2'd1, 1, 4'h2);
        add(0, 4'hF, 4'hF, 1, 16'h0,    4'h0, 2'd1, 0, 4'h0);
        add(0, 4'hF, 4'hF, 1, 16'h0,    4'h4, 2'd2, 1, 4'h4);
        add(0, 4'hF, 4'hF, 1, 16'h0,    4'h0, 2'd2, 0, 4'h0);
        add(0, 4'hF, 4'hF, 1, 16'h0,    4'h8, 2'd3, 1, 4'h8);
        add(0, 4'hF, 4'hF, 1, 16'h0,    4'h0, 2'd3, 0, 4'h0);
        add(0, 4'hF, 4'hF, 1, 16'h0,    4'h1, 2'd0, 1, 4'h1);
        add(0, 4'h0, 4'h0, 1, 16'h0,    4'h0, 2'd0, 0, 4'h0);
        // three-beat burst on requester 2
        add(0, 4'h4, 4'h0, 1, 16'h1111, 4'h0, 2'd0, 0, 4'h0);
        add(0, 4'h4, 4'h0, 1, 16'h1111, 4'h4, 2'd2, 1, 4'h4);
        add(0, 4'h4, 4'h0, 1, 16'h2222, 4'h4, 2'd2, 1, 4'h4);
        add(0, 4'h4, 4'h4, 1, 16'h3333, 4'h4, 2'd2, 1, 4'h4);
        add(0, 4'hF, 4'hF, 1, 16'h0,    4'h0, 2'd2, 0, 4'h0);
        add(0, 4'hF, 4'hF, 1, 16'h0,    4'h8, 2'd3, 1, 4'h8);
        add(0, 4'h0, 4'h0, 1, 16'h0,    4'h0, 2'd3, 0, 4'h0);
        // requester 1: one beat, 4-cycle stall, then hog until forced release
        add(0, 4'h2, 4'h0, 1, 16'h0,    4'h0, 2'd3, 0, 4'h0);
        add(0, 4'h2, 4'h0, 1, 16'h0,    4'h2, 2'd1, 1, 4'h2);
        for (int i = 0; i < 4; i++)
            add(0, 4'h2, 4'h0, 0, 16'h0, 4'h2, 2'd1, 1, 4'h0);
        for (int i = 0; i < 7; i++)
            add(0, 4'hA, 4'h8, 1, 16'h0, 4'h2, 2'd1, 1, 4'h2);
        add(0, 4'hA, 4'h8, 1, 16'h0,    4'h0, 2'd1, 0, 4'h0);
        add(0, 4'hA, 4'h8, 1, 16'h0,    4'h8, 2'd3, 1, 4'h8);
        add(0, 4'h0, 4'h0, 1, 16'h0,    4'h0, 2'd3, 0, 4'h0);
        // abandon on requester 2, then pointer must sit at 3
        add(0, 4'h4, 4'h0, 1, 16'h5555, 4'h0, 2'd3, 0, 4'h0);
        add(0, 4'h4, 4'h0, 1, 16'h5555, 4'h4, 2'd2, 1, 4'h4);
        add(0, 4'h0, 4'h0, 1, 16'h5555, 4'h4, 2'd2, 0, 4'h0);
        add(0, 4'h0, 4'h0, 1, 16'h5555, 4'h0, 2'd2, 0, 4'h0);
        add(0, 4'hD, 4'hD, 1, 16'h5555, 4'h0, 2'd2, 0, 4'h0);
        add(0, 4'hD, 4'hD, 1, 16'h5555, 4'h8, 2'd3, 1, 4'h8);
        add(0, 4'h0, 4'h0, 1, 16'h5555, 4'h0, 2'd3, 0, 4'h0);
        // reset mid-burst on requester 1
        add(0, 4'h2, 4'h0, 1, 16'h5555, 4'h0, 2'd3, 0, 4'h0);
        add(0, 4'h2, 4'h0, 1, 16'h5555, 4'h2, 2'd1, 1, 4'h2);
        add(1, 4'h2, 4'h0, 1, 16'h5555, 4'h2, 2'd1, 0, 4'h0);
        add(0, 4'h2, 4'h0, 1, 16'h5555, 4'h0, 2'd0, 0, 4'h0);
        add(0, 4'h0, 4'h0, 1, 16'h5555, 4'h2, 2'd1, 0, 4'h0);
        add(0, 4'h0, 4'h0, 1, 16'h5555, 4'h0, 2'd1, 0, 4'h0);

        have_prev = 1'b0;
        prev_ack  = 4'h0;
        prev      = vecs[0];
        foreach (vecs[n]) begin
            @(posedge clk);
            #1;
            rst           = vecs[n].rst;
            bus.req       = vecs[n].req;
            bus.last      = vecs[n].last;
            bus.outReady  = vecs[n].rdy;
            bus.data2     = vecs[n].d2;
            exp_q.push_back(vecs[n]);
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("grant[%0d]", n), 32'(bus.grant), 32'(e.g));
            chk($sformatf("sel[%0d]", n), 32'(bus.sel), 32'(e.s));
            chk($sformatf("outValid[%0d]", n), 32'(bus.outValid), 32'(e.v));
            chk($sformatf("beatAck[%0d]", n), 32'(bus.beatAck), 32'(e.a));
            chk($sformatf("outData[%0d]", n), 32'(bus.outData),
                32'((e.g != 4'h0) ? dsel(e.s, e.d2) : 16'h0));
            // requester rule: data/last held while a request waits unacked
            if (have_prev) begin
                for (int i = 0; i < 4; i++) begin
                    if (prev.req[i] && !prev_ack[i] && e.req[i] && !e.rst) begin
                        chk($sformatf("hold_last%0d[%0d]", i, n),
                            32'(e.last[i]), 32'(prev.last[i]));
                        if (i == 2)
                            chk($sformatf("hold_data2[%0d]", n), 32'(e.d2), 32'(prev.d2));
                    end
                end
            end
            prev      = e;
            prev_ack  = bus.beatAck;
            have_prev = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
